// File: rtl/pps_mem_access_pkg.sv
// Shared definitions for the memory-access stage: memop_type bit positions,
// FSM state encoding, access sizes and byte-enable constants.
package pps_mem_access_pkg;

    localparam int MT_BYTE     = 0;
    localparam int MT_HALF     = 1;
    localparam int MT_WORD     = 2;
    localparam int MT_UNSIGNED = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;

    // Byte wins over half; anything else (word bit, reserved bits, nothing) is a word.
    function automatic size_e decode_size(input logic [1:0] size_bits);
        if (size_bits[0]) return SZ_BYTE;
        if (size_bits[1]) return SZ_HALF;
        return SZ_WORD;
    endfunction

endpackage

// File: rtl/pps_mem_access_mem_load_align.sv
// Load lane select and sign/zero extension of a big-endian SRAM read word.
module mem_load_align
    import pps_mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic uns);
        logic signed [7:0]  s;
        logic signed [31:0] w;
        s = b;
        w = s;
        return uns ? {24'b0, b} : w;
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic uns);
        logic signed [15:0] s;
        logic signed [31:0] w;
        s = h;
        w = s;
        return uns ? {16'b0, h} : w;
    endfunction

    // Offset 0 is the most significant lane.
    always_comb begin
        byte_lane = rdata[31:24];
        case (offset)
            2'd0: byte_lane = rdata[31:24];
            2'd1: byte_lane = rdata[23:16];
            2'd2: byte_lane = rdata[15:8];
            2'd3: byte_lane = rdata[7:0];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        result = rdata;
        case (size)
            SZ_BYTE: result = extend8(byte_lane, is_unsigned);
            SZ_HALF: result = extend16(half_lane, is_unsigned);
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/pps_mem_access.sv
// Memory-access pipeline stage: SRAM request generation, one-cycle load FSM,
// load alignment and the registered write-back triple.
module pps_mem_access
    import pps_mem_access_pkg::*;
#(
    parameter int ADDR_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       EX_alu_result_in,
    input  logic [31:0]       EX_store_data_in,
    input  logic [4:0]        EX_inst_rd_in,
    input  logic              EX_RegWrite_in,
    input  logic              EX_memop_in,
    input  logic              EX_memwr_in,
    input  logic [6:0]        EX_memop_type_in,
    output logic              MEM_busy_out,
    output logic              MEM_addr_err_out,
    output logic              sram_ce_out,
    output logic              sram_we_out,
    output logic [3:0]        sram_be_out,
    output logic [ADDR_W-1:0] sram_addr_out,
    output logic [31:0]       sram_wdata_out,
    input  logic [31:0]       sram_rdata_in,
    output logic [31:0]       WB_RF_Wdata_out,
    output logic [4:0]        WB_inst_rd_out,
    output logic              WB_RegWrite_out
);

    state_e      state, next_state;
    size_e       size_ex, size_p1;
    logic [1:0]  off_ex, off_p1;
    logic        uns_p1;
    logic        misaligned;
    logic [3:0]  store_be;
    logic [31:0] load_data;
    logic [31:0] wb_data_d;
    logic [4:0]  wb_rd_d;
    logic        wb_we_d;
    logic        unused_type;

    assign unused_type   = ^{EX_memop_type_in[6:4], EX_memop_type_in[MT_WORD]};
    assign size_ex       = decode_size(EX_memop_type_in[MT_HALF:MT_BYTE]);
    assign off_ex        = EX_alu_result_in[1:0];
    assign sram_addr_out = EX_alu_result_in[ADDR_W+1:2];

    // Issue stage: alignment, byte enables and lane-replicated store data
    always_comb begin
        misaligned     = 1'b0;
        store_be       = BE_ALL;
        sram_wdata_out = EX_store_data_in;
        case (size_ex)
            SZ_BYTE: begin
                store_be       = BE_BYTE0 >> off_ex;
                sram_wdata_out = {4{EX_store_data_in[7:0]}};
            end
            SZ_HALF: begin
                misaligned     = off_ex[0];
                store_be       = off_ex[1] ? BE_HALF_LO : BE_HALF_HI;
                sram_wdata_out = {2{EX_store_data_in[15:0]}};
            end
            default: begin
                misaligned = (off_ex != 2'd0);
            end
        endcase
    end

    always_comb begin
        next_state       = state;
        sram_ce_out      = 1'b0;
        sram_we_out      = 1'b0;
        sram_be_out      = BE_NONE;
        MEM_busy_out     = 1'b0;
        MEM_addr_err_out = 1'b0;
        wb_data_d        = EX_alu_result_in;
        wb_rd_d          = EX_inst_rd_in;
        wb_we_d          = EX_RegWrite_in;
        case (state)
            ST_IDLE: begin
                if (EX_memop_in) begin
                    wb_we_d = 1'b0;
                    if (misaligned) begin
                        MEM_addr_err_out = 1'b1;
                    end else if (EX_memwr_in) begin
                        sram_ce_out = 1'b1;
                        sram_we_out = 1'b1;
                        sram_be_out = store_be;
                    end else begin
                        sram_ce_out  = 1'b1;
                        sram_be_out  = BE_ALL;
                        MEM_busy_out = 1'b1;
                        next_state   = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                // EX_* is still the held load; only the aligned read data changes.
                wb_data_d  = load_data;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (rst) begin
            sram_ce_out      = 1'b0;
            sram_we_out      = 1'b0;
            sram_be_out      = BE_NONE;
            MEM_busy_out     = 1'b0;
            MEM_addr_err_out = 1'b0;
            next_state       = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Capture stage: offset/size of the issuing load, used in the LOAD cycle
    always_ff @(posedge clk) begin
        if (state == ST_IDLE) begin
            off_p1  <= off_ex;
            size_p1 <= size_ex;
            uns_p1  <= EX_memop_type_in[MT_UNSIGNED];
        end
    end

    mem_load_align u_align (
        .rdata       (sram_rdata_in),
        .offset      (off_p1),
        .size        (size_p1),
        .is_unsigned (uns_p1),
        .result      (load_data)
    );

    // Write-back stage
    always_ff @(posedge clk) begin
        if (rst) begin
            WB_RF_Wdata_out <= 32'd0;
            WB_inst_rd_out  <= 5'd0;
            WB_RegWrite_out <= 1'b0;
        end else begin
            WB_RF_Wdata_out <= wb_data_d;
            WB_inst_rd_out  <= wb_rd_d;
            WB_RegWrite_out <= wb_we_d;
        end
    end

endmodule

// File: tb/tb_pps_mem_access.sv
// Scoreboard bench for pps_mem_access against a byte-addressed big-endian memory model.
module tb_pps_mem_access;

    localparam int ADDR_W = 18;

    logic              clk;
    logic              rst;
    logic [31:0]       EX_alu_result_in;
    logic [31:0]       EX_store_data_in;
    logic [4:0]        EX_inst_rd_in;
    logic              EX_RegWrite_in;
    logic              EX_memop_in;
    logic              EX_memwr_in;
    logic [6:0]        EX_memop_type_in;
    logic              MEM_busy_out;
    logic              MEM_addr_err_out;
    logic              sram_ce_out;
    logic              sram_we_out;
    logic [3:0]        sram_be_out;
    logic [ADDR_W-1:0] sram_addr_out;
    logic [31:0]       sram_wdata_out;
    logic [31:0]       sram_rdata;
    logic [31:0]       WB_RF_Wdata_out;
    logic [4:0]        WB_inst_rd_out;
    logic              WB_RegWrite_out;

    pps_mem_access #(.ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .EX_alu_result_in (EX_alu_result_in),
        .EX_store_data_in (EX_store_data_in),
        .EX_inst_rd_in    (EX_inst_rd_in),
        .EX_RegWrite_in   (EX_RegWrite_in),
        .EX_memop_in      (EX_memop_in),
        .EX_memwr_in      (EX_memwr_in),
        .EX_memop_type_in (EX_memop_type_in),
        .MEM_busy_out     (MEM_busy_out),
        .MEM_addr_err_out (MEM_addr_err_out),
        .sram_ce_out      (sram_ce_out),
        .sram_we_out      (sram_we_out),
        .sram_be_out      (sram_be_out),
        .sram_addr_out    (sram_addr_out),
        .sram_wdata_out   (sram_wdata_out),
        .sram_rdata_in    (sram_rdata),
        .WB_RF_Wdata_out  (WB_RF_Wdata_out),
        .WB_inst_rd_out   (WB_inst_rd_out),
        .WB_RegWrite_out  (WB_RegWrite_out)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] sram [0:255];

    localparam logic [6:0] T_B  = 7'b0000001;
    localparam logic [6:0] T_BU = 7'b0001001;
    localparam logic [6:0] T_H  = 7'b0000010;
    localparam logic [6:0] T_HU = 7'b0001010;
    localparam logic [6:0] T_W  = 7'b0000100;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM environment model: word array, read data one cycle after request
    always @(posedge clk) begin
        if (sram_ce_out) begin
            if (sram_we_out) begin
                for (int i = 0; i < 4; i++)
                    if (sram_be_out[i]) sram[sram_addr_out[7:0]][8*i +: 8] = sram_wdata_out[8*i +: 8];
            end else begin
                sram_rdata <= sram[sram_addr_out[7:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input int a, input int sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        if (sz == 0) begin
            b = ref_mem[a];
            return uns ? {24'd0, b} : 32'($signed(b));
        end
        if (sz == 1) begin
            h = {ref_mem[a], ref_mem[a+1]};
            return uns ? {16'd0, h} : 32'($signed(h));
        end
        return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    endfunction

    task automatic ref_store(input int a, input int sz, input logic [31:0] d);
        int n;
        n = 1 << sz;
        for (int k = 0; k < n; k++) ref_mem[a+k] = d[8*(n-1-k) +: 8];
    endtask

    // Presents one operation at posedge+1 and returns at posedge+1 of the next free cycle.
    task automatic do_op(input logic memop, input logic memwr, input logic [6:0] mtype,
                         input logic [31:0] alu, input logic [31:0] sdata, input logic [4:0] rd,
                         input logic regw, input bit rst_in_load);
        int          sz, n, a, off;
        logic        aligned, is_load;
        logic [3:0]  be;
        logic [31:0] wd, ld;
        EX_memop_in      = memop;
        EX_memwr_in      = memwr;
        EX_memop_type_in = mtype;
        EX_alu_result_in = alu;
        EX_store_data_in = sdata;
        EX_inst_rd_in    = rd;
        EX_RegWrite_in   = regw;
        a       = int'(alu[9:0]);
        off     = a % 4;
        sz      = mtype[0] ? 0 : (mtype[1] ? 1 : 2);
        n       = 1 << sz;
        aligned = ((a % n) == 0);
        is_load = memop && !memwr && aligned;
        ld      = 32'd0;
        #1;
        chk("addr_err", 32'(MEM_addr_err_out), 32'(memop && !aligned));
        chk("sram_ce", 32'(sram_ce_out), 32'(memop && aligned));
        chk("busy_issue", 32'(MEM_busy_out), 32'(is_load));
        if (memop && aligned) begin
            be = 4'd0;
            for (int k = 0; k < n; k++) be[3-(off+k)] = 1'b1;
            chk("sram_we", 32'(sram_we_out), 32'(memwr));
            chk("sram_be", 32'(sram_be_out), 32'(memwr ? be : 4'hF));
            chk("sram_addr", 32'(sram_addr_out), 32'(alu >> 2));
            if (memwr) begin
                wd = (sz == 0) ? {4{sdata[7:0]}} : ((sz == 1) ? {2{sdata[15:0]}} : sdata);
                chk("sram_wdata", sram_wdata_out, wd);
                ref_store(a, sz, sdata);
            end else begin
                ld = ref_load(a, sz, mtype[3]);
            end
        end
        if (!memop && regw) q.push_back('{alu, rd, cyc + 1});
        @(posedge clk); #1;
        if (is_load) begin
            chk("busy_load_cycle", 32'(MEM_busy_out), 32'd0);
            chk("ce_load_cycle", 32'(sram_ce_out), 32'd0);
            if (rst_in_load) rst = 1'b1;
            else if (regw) q.push_back('{ld, rd, cyc + 1});
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    // Monitor: every register write must match the oldest expected write, in the right cycle
    always @(negedge clk) begin
        if (!rst && WB_RegWrite_out) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got write rd %0d data %h expected no write",
                         WB_inst_rd_out, WB_RF_Wdata_out);
            end else begin
                mon_e = q.pop_front();
                chk("wb_data", WB_RF_Wdata_out, mon_e.data);
                chk("wb_rd", 32'(WB_inst_rd_out), 32'(mon_e.rd));
                chk("wb_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          kind, szsel, a;
        logic [6:0]  mt;
        logic [31:0] alu;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
        for (int i = 0; i < 256; i++) sram[i] = 32'd0;

        rst              = 1'b1;
        EX_memop_in      = 1'b1;
        EX_memwr_in      = 1'b0;
        EX_memop_type_in = T_W;
        EX_alu_result_in = 32'h104;
        EX_store_data_in = 32'd0;
        EX_inst_rd_in    = 5'd4;
        EX_RegWrite_in   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_data", WB_RF_Wdata_out, 32'd0);
        chk("rst_wb_rd", 32'(WB_inst_rd_out), 32'd0);
        chk("rst_wb_we", 32'(WB_RegWrite_out), 32'd0);
        chk("rst_sram_ce", 32'(sram_ce_out), 32'd0);
        chk("rst_busy", 32'(MEM_busy_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(1, 1, T_W,  32'h104, 32'hDEADBEEF, 5'd0, 1'b0, 0);
        do_op(1, 0, T_W,  32'h104, 32'd0, 5'd5, 1'b1, 0);
        do_op(1, 1, T_B,  32'h102, 32'h000000A5, 5'd0, 1'b0, 0);
        do_op(1, 0, T_B,  32'h102, 32'd0, 5'd6, 1'b1, 0);
        do_op(1, 0, T_BU, 32'h102, 32'd0, 5'd7, 1'b1, 0);
        do_op(1, 1, T_W,  32'h104, 32'h80017FFF, 5'd0, 1'b0, 0);
        do_op(1, 0, T_H,  32'h106, 32'd0, 5'd8, 1'b1, 0);
        do_op(1, 0, T_H,  32'h104, 32'd0, 5'd9, 1'b1, 0);
        do_op(1, 0, T_HU, 32'h104, 32'd0, 5'd10, 1'b1, 0);
        do_op(1, 0, T_W,  32'h105, 32'd0, 5'd11, 1'b1, 0);
        do_op(0, 0, 7'd0, 32'h12345678, 32'd0, 5'd3, 1'b1, 0);
        do_op(1, 0, T_W,  32'h104, 32'd0, 5'd12, 1'b1, 0);
        do_op(1, 0, T_W,  32'h100, 32'd0, 5'd13, 1'b1, 1);
        do_op(1, 1, T_W,  32'h108, 32'h0BADF00D, 5'd0, 1'b0, 0);
        do_op(1, 0, T_W,  32'h108, 32'd0, 5'd0, 1'b1, 0);
        do_op(1, 0, 7'b1110000, 32'h108, 32'd0, 5'd14, 1'b1, 0);

        for (int i = 0; i < 400; i++) begin
            kind  = $urandom_range(0, 2);
            szsel = $urandom_range(0, 3);
            mt    = (szsel < 3) ? 7'(1 << szsel) : 7'd0;
            mt    = mt | 7'($urandom_range(0, 1) << 3) | 7'($urandom_range(0, 7) << 4);
            a     = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) begin
                if (szsel == 1) a = a & ~1;
                else if (szsel != 0) a = a & ~3;
            end
            alu = (kind == 0) ? $urandom : 32'(a);
            do_op(kind != 0, kind == 1, mt, alu, $urandom, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0);
        end

        EX_memop_in    = 1'b0;
        EX_RegWrite_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
